fc_stream_neuron: RTL and testbench

FC_STREAM_NEURON -- requirements
Module: fc_stream_neuron

---
 rtl/fc_pkg.sv | 25 ++
 rtl/fc_lane_tree.sv | 51 +++++
 rtl/fc_stream_neuron.sv | 149 ++++++++++++++
 tb/tb_fc_stream_neuron.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and sizing helpers for the streaming fully-connected neuron.
package fc_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_FLUSH,
        S_OUT
    } fc_state_e;

    localparam int FC_WIDTH = 8;
    localparam int FC_LANES = 4;

    // One input beat in the default lane/width configuration
    typedef logic [FC_LANES-1:0][FC_WIDTH-1:0] fc_lanes_t;

    function automatic int fc_acc_w(input int width, input int n);
        return 2 * width + $clog2(n);
    endfunction

    function automatic int fc_beats(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/fc_lane_tree.sv
// Per-lane signed products followed by a registered lane adder tree.
// Two cycles from valid_i to valid_o.
module fc_lane_tree #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    localparam int SW = 2 * WIDTH + $clog2(LANES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    input  logic [LANES-1:0][WIDTH-1:0]  act_i,
    input  logic [LANES-1:0][WIDTH-1:0]  w_i,
    output logic                         valid_o,
    output logic signed [SW-1:0]         sum_o
);

    logic signed [2*WIDTH-1:0] prod_q [LANES];
    logic signed [SW-1:0]      sum_q;
    logic signed [SW-1:0]      sum_d;
    logic                      v1_q;
    logic                      v2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            sum_q <= '0;
            for (int j = 0; j < LANES; j++) begin
                prod_q[j] <= '0;
            end
        end else begin
            v1_q  <= valid_i;
            v2_q  <= v1_q;
            sum_q <= sum_d;
            for (int j = 0; j < LANES; j++) begin
                prod_q[j] <= $signed(act_i[j]) * $signed(w_i[j]);
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int j = 0; j < LANES; j++) begin
            sum_d = sum_d + SW'(prod_q[j]);
        end
    end

    assign valid_o = v2_q;
    assign sum_o   = sum_q;

endmodule

// File: rtl/fc_stream_neuron.sv
// Streaming neuron: z = sum(x[i]*w[i]) over LANES activations per beat.
// Define FC_RELU_EN to clamp negative results to zero.
module fc_stream_neuron
    import fc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IN    = 400,
    parameter int LANES = 4,
    localparam int BEATS = fc_beats(IN, LANES),
    localparam int ACC_W = fc_acc_w(WIDTH, IN),
    localparam int AW    = (IN > 1) ? $clog2(IN) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        w_we,
    input  logic [AW-1:0]               w_addr,
    input  logic [WIDTH-1:0]            w_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES-1:0][WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            z
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SW = 2 * WIDTH + $clog2(LANES);

    logic [WIDTH-1:0]            w_q [IN];
    fc_state_e                   state_q;
    logic [CW-1:0]               cnt_q;
    logic [1:0]                  fl_q;
    logic                        rdy_q;
    logic                        vld_q;
    logic signed [ACC_W-1:0]     acc_q;
    logic signed [ACC_W-1:0]     z_q;
    logic signed [ACC_W-1:0]     z_d;
    logic                        accept;
    logic                        last_beat;
    logic                        t_valid;
    logic signed [SW-1:0]        t_sum;
    logic [LANES-1:0][WIDTH-1:0] w_lane;
    logic [LANES-1:0][WIDTH-1:0] a_lane;
    int                          idx;

    assign accept    = in_valid & rdy_q;
    assign last_beat = (cnt_q == CW'(BEATS - 1));
    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign z         = z_q;

    // A write that lands on the first beat is dropped so the vector
    // in flight only ever sees one weight set.
    always_ff @(posedge clk) begin
        if (w_we && state_q == S_IDLE && !accept && int'(w_addr) < IN) begin
            w_q[w_addr] <= w_data;
        end
    end

    always_comb begin
        w_lane = '0;
        a_lane = '0;
        idx    = 0;
        for (int j = 0; j < LANES; j++) begin
            idx = int'(cnt_q) * LANES + j;
            if (idx < IN) begin
                w_lane[j] = w_q[idx[AW-1:0]];
                a_lane[j] = in_data[j];
            end
        end
    end

    fc_lane_tree #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_tree (
        .clk     (clk),
        .rst     (rst),
        .valid_i (accept),
        .act_i   (a_lane),
        .w_i     (w_lane),
        .valid_o (t_valid),
        .sum_o   (t_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (accept && state_q == S_IDLE) begin
            acc_q <= '0;
        end else if (t_valid) begin
            acc_q <= acc_q + ACC_W'(t_sum);
        end
    end

    always_comb begin
`ifdef FC_RELU_EN
        z_d = acc_q[ACC_W-1] ? '0 : acc_q;
`else
        z_d = acc_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fl_q    <= '0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            z_q     <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_ACC: begin
                    if (accept) begin
                        if (last_beat) begin
                            cnt_q   <= '0;
                            fl_q    <= '0;
                            rdy_q   <= 1'b0;
                            state_q <= S_FLUSH;
                        end else begin
                            cnt_q   <= cnt_q + CW'(1);
                            state_q <= S_ACC;
                        end
                    end
                end
                // Wait for the last beat to drain through tree and accumulator
                S_FLUSH: begin
                    if (fl_q == 2'd2) begin
                        state_q <= S_OUT;
                        vld_q   <= 1'b1;
                        z_q     <= z_d;
                    end else begin
                        fl_q <= fl_q + 2'd1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                        vld_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                        z_q     <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_stream_neuron.sv
// Randomised bench for fc_stream_neuron against a plain dot-product model.
module tb_fc_stream_neuron;
    import fc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            a_we, a_iv, a_ir, a_ov, a_or;
    logic [8:0]      a_addr;
    logic [7:0]      a_wd;
    fc_lanes_t       a_id;
    logic [24:0]     a_z;

    logic            b_we, b_iv, b_ir, b_ov, b_or;
    logic [3:0]      b_addr;
    logic [7:0]      b_wd;
    fc_lanes_t       b_id;
    logic [19:0]     b_z;

    int total = 0;
    int bad   = 0;
    int wm [2][400];
    int xm [2][400];
    int nin [2] = '{400, 10};

    fc_stream_neuron #(.WIDTH(8), .IN(400), .LANES(4)) dut_a (
        .clk(clk), .rst(rst), .w_we(a_we), .w_addr(a_addr), .w_data(a_wd),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .z(a_z)
    );

    fc_stream_neuron #(.WIDTH(8), .IN(10), .LANES(4)) dut_b (
        .clk(clk), .rst(rst), .w_we(b_we), .w_addr(b_addr), .w_data(b_wd),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .z(b_z)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int r8();
        logic [7:0] v;
        v = 8'($urandom);
        return int'($signed(v));
    endfunction

    function automatic longint zval(input int sel);
        return sel ? longint'($signed(b_z)) : longint'($signed(a_z));
    endfunction

    function automatic logic ovv(input int sel);
        return sel ? b_ov : a_ov;
    endfunction

    function automatic logic irv(input int sel);
        return sel ? b_ir : a_ir;
    endfunction

    function automatic longint model(input int sel);
        longint s;
        s = 0;
        for (int i = 0; i < nin[sel]; i++) s += longint'(xm[sel][i]) * longint'(wm[sel][i]);
`ifdef FC_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    function automatic fc_lanes_t beat_data(input int sel, input int b);
        fc_lanes_t pk;
        int idx;
        for (int j = 0; j < 4; j++) begin
            idx = b * 4 + j;
            pk[j] = (idx < nin[sel]) ? 8'(xm[sel][idx]) : 8'(127);
        end
        return pk;
    endfunction

    task automatic set_in(input int sel, input logic v, input fc_lanes_t d);
        if (sel != 0) begin b_iv = v; b_id = d; end
        else begin a_iv = v; a_id = d; end
    endtask

    task automatic set_we(input int sel, input logic we, input int addr, input int data);
        if (sel != 0) begin b_we = we; b_addr = 4'(addr); b_wd = 8'(data); end
        else begin a_we = we; a_addr = 9'(addr); a_wd = 8'(data); end
    endtask

    task automatic set_or(input int sel, input logic v);
        if (sel != 0) b_or = v;
        else a_or = v;
    endtask

    task automatic load_w(input int sel);
        for (int i = 0; i < nin[sel]; i++) begin
            @(negedge clk);
            set_we(sel, 1'b1, i, wm[sel][i]);
        end
        @(negedge clk);
        set_we(sel, 1'b0, 0, 0);
    endtask

    task automatic run(input int sel, input string tag, input int stall_pct,
                       input int hold, input int cw_addr);
        int nb;
        int lat;
        nb = (nin[sel] + 3) / 4;
        for (int b = 0; b < nb; b++) begin
            while ($urandom_range(0, 99) < stall_pct) begin
                @(negedge clk);
                set_we(sel, 1'b0, 0, 0);
                set_in(sel, 1'b0, '0);
            end
            @(negedge clk);
            set_we(sel, 1'b0, 0, 0);
            set_in(sel, 1'b1, beat_data(sel, b));
            if (b == 0 && cw_addr >= 0) set_we(sel, 1'b1, cw_addr, ~wm[sel][cw_addr]);
        end
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, '0);
        set_we(sel, 1'b0, 0, 0);
        lat = 0;
        while (!ovv(sel) && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_z"}, zval(sel), model(sel));
        if (hold > 0) set_in(sel, 1'b1, beat_data(sel, 0));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_z"}, zval(sel), model(sel));
            chk({tag, "_hold_rdy"}, longint'(irv(sel)), 0);
            chk({tag, "_hold_ov"}, longint'(ovv(sel)), 1);
        end
        @(negedge clk);
        set_in(sel, 1'b0, '0);
        set_or(sel, 1'b1);
        @(posedge clk);
        #1;
        chk({tag, "_rel_ov"}, longint'(ovv(sel)), 0);
        chk({tag, "_rel_rdy"}, longint'(irv(sel)), 1);
        set_or(sel, 1'b0);
    endtask

    initial begin
        #5000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        a_we = 0; a_iv = 0; a_or = 0; a_addr = '0; a_wd = '0; a_id = '0;
        b_we = 0; b_iv = 0; b_or = 0; b_addr = '0; b_wd = '0; b_id = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy", longint'(a_ir), 1);
        chk("rst_ov", longint'(a_ov), 0);
        chk("rst_z", zval(0), 0);
        chk("rst_rdy_b", longint'(b_ir), 1);

        for (int i = 0; i < 400; i++) begin wm[0][i] = 1; xm[0][i] = 1; end
        load_w(0);
        run(0, "ones", 0, 0, -1);

        for (int i = 0; i < 400; i++) begin wm[0][i] = -128; xm[0][i] = -128; end
        load_w(0);
        run(0, "minmin", 20, 0, -1);

        for (int i = 0; i < 400; i++) begin wm[0][i] = -1; xm[0][i] = 1; end
        load_w(0);
        run(0, "neg", 0, 10, -1);

        for (int i = 0; i < 400; i++) wm[0][i] = r8();
        load_w(0);
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 400; i++) xm[0][i] = r8();
            run(0, "rand", 30, 0, -1);
        end

        for (int i = 0; i < 400; i++) xm[0][i] = r8();
        for (int b = 0; b < 50; b++) begin
            @(negedge clk);
            set_in(0, 1'b1, beat_data(0, b));
        end
        @(negedge clk);
        set_in(0, 1'b0, '0);
        set_we(0, 1'b1, 5, ~wm[0][5]);
        @(negedge clk);
        set_we(0, 1'b0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ov", longint'(a_ov), 0);
        chk("mid_rst_z", zval(0), 0);
        chk("mid_rst_rdy", longint'(a_ir), 1);
        for (int i = 0; i < 400; i++) xm[0][i] = r8();
        xm[0][5] = 100;
        run(0, "after_rst", 10, 0, -1);

        for (int i = 0; i < 400; i++) xm[0][i] = r8();
        xm[0][399] = 50;
        run(0, "coinc", 0, 0, 399);

        for (int i = 0; i < 10; i++) wm[1][i] = r8();
        load_w(1);
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 10; i++) xm[1][i] = r8();
            run(1, "n10", 20, 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
